mcycle_control: RTL and testbench
=================================

# mcycle_control

Main control sequencer for the multi-cycle MIPS datapath. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and write-back. In each state it drives the shared ALU's `aluop1`/`aluop0` pair, which feeds the ALU-control decoder, plus the memory, register-file, IR and PC enables. It sits between the instruction register's opcode field and the datapath muxes, and stretches memory states with a ready handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces state FETCH.
- `opcode` in 6: IR[31:26], stable from DECODE until the instruction retires.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC load enable, equal to `pcwrite | (pcwritecond & taken)`.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca` out 1 each: datapath controls.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `pcsource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `aluop1`, `aluop0` out 1 each: 00 = add, 01 = subtract, 10 = R-type function decode.
- `illegal` out 1: pulses in DECODE on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are a function of state only, except where `mem_ready`, `opcode` or `zero` is named. Any control not listed for a state is 0.
- FETCH (0):
  - Drives memread, alusrcb=01, aluop=00, pcsource=00.
  - irwrite = pcwrite = `mem_ready`.
  - Holds in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE (1): alusrcb=11, aluop=00. Next state by opcode:
  - lw or sw → MEMADR.
  - R-type → EXEC.
  - beq → BRANCH.
  - j → JUMP.
  - addi → ADDIEX.
  - Any other opcode → FETCH with illegal=1.
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): memread=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB (4): regwrite=1, memtoreg=1, regdst=0. Goes to FETCH.
- MEMWR (5): memwrite=1, iord=1. Holds until mem_ready, then goes to FETCH.
- EXEC (6): alusrca=1, alusrcb=00, aluop=10. Goes to RWB.
- RWB (7): regwrite=1, regdst=1. Goes to FETCH.
- BRANCH (8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. taken = `zero`. Goes to FETCH.
- JUMP (9): pcwrite=1, pcsource=10. Goes to FETCH.
- ADDIEX (10): alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB (11): regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.
- Codes 12-15 are unreachable. If entered, the FSM returns to FETCH on the next edge with all outputs 0.

## Timing
- Reset:
  - `state` = 0 asynchronously.
  - While `reset` is high, pcwrite, irwrite, pcen, regwrite and memwrite are forced to 0. All other outputs take their FETCH values.
  - The first fetch completes on the first edge after deassertion at which mem_ready = 1.
- Latency with zero wait states (mem_ready always 1):
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - addi: 4 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle. While waiting, outputs stay constant and no enable fires.
- A reset asserted mid-instruction abandons that instruction immediately. No partial writeback occurs after assertion.
- `pcen` is combinational from state and `zero`, and is valid in the same cycle.

## Configuration
- `MCTRL_BNE_EN` defined:
  - Opcode 000101 (bne) decodes in DECODE to BRANCH.
  - In BRANCH, taken = `~zero` when opcode = 000101, otherwise `zero`.
- `MCTRL_BNE_EN` undefined: 000101 is treated as illegal (illegal=1, return to FETCH).

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → state 0, pcen=0 during reset; state=1 and irwrite pulsed exactly once on the first post-reset edge.
- R-type (opcode 000000), mem_ready=1 → states 0,1,6,7,0; aluop=10 in EXEC; regwrite=1 and regdst=1 only in RWB.
- lw with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; memread and iord stay high throughout MEMRD; memtoreg=1 and regwrite=1 in MEMWB.
- beq with zero=1, then again with zero=0 → pcen=1 and pcen=0 respectively in BRANCH; aluop=01, pcsource=01 in both cases.
- j → pcwrite=1, pcsource=10 in JUMP. Opcode 111111 → illegal=1 in DECODE, then next state 0.
- With `MCTRL_BNE_EN` defined, opcode 000101 and zero=0 → pcen=1. Without it → illegal=1.

Source files
------------

// File: rtl/mcycle_control_if.sv
// mcycle_control_if: control bundle between the multi-cycle MIPS control
// sequencer and the datapath.
//   master (sequencer): opcode, zero, mem_ready in; every control out.
//   slave  (datapath) : the mirror image.
//   opcode    : IR[31:26]
//   zero      : ALU zero flag
//   mem_ready : memory completes the current access this cycle
//   pcen      : PC load enable, pcwrite | (pcwritecond & taken)
//   alusrcb   : 00 B, 01 four, 10 sign-ext imm, 11 shifted imm
//   pcsource  : 00 ALU, 01 ALUOut, 10 jump target
//   aluop1/0  : 00 add, 01 subtract, 10 function-field decode
//   illegal   : unsupported opcode seen in DECODE
//   state     : current sequencer state, for debug
interface mcycle_control_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       pcwrite;
   logic       pcwritecond;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       memtoreg;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsource;
   logic       aluop1;
   logic       aluop0;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pcen, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
             irwrite, regwrite, regdst, alusrca, alusrcb, pcsource,
             aluop1, aluop0, illegal, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pcen, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
             irwrite, regwrite, regdst, alusrca, alusrcb, pcsource,
             aluop1, aluop0, illegal, state
   );
endinterface

// File: rtl/mcycle_control.sv
// mcycle_control: Moore-style main control sequencer for the multi-cycle
// MIPS datapath (fetch, decode, execute, memory, write-back).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH
//   bus   : mcycle_control_if.master (opcode/zero/mem_ready in, controls out)
// Optional feature: define MCTRL_BNE_EN to decode bne (000101) as a branch
// taken on ~zero; without it 000101 is an illegal opcode.
module mcycle_control (
   input logic             clk,
   input logic             reset,
   mcycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MCTRL_BNE_EN
   localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

   state_t state_q, state_next;
   logic   legal;
   logic   taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_next;
   end

   always_comb begin
      legal = 1'b1;
      case (bus.opcode)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
`ifdef MCTRL_BNE_EN
         OP_BNE: legal = 1'b1;
`endif
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_next = FETCH;
      case (state_q)
         FETCH:  state_next = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXEC;
               OP_BEQ:       state_next = BRANCH;
`ifdef MCTRL_BNE_EN
               OP_BNE:       state_next = BRANCH;
`endif
               OP_J:         state_next = JUMP;
               OP_ADDI:      state_next = ADDIEX;
               default:      state_next = FETCH;
            endcase
         end
         MEMADR: state_next = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  state_next = bus.mem_ready ? MEMWB : MEMRD;
         MEMWB:  state_next = FETCH;
         MEMWR:  state_next = bus.mem_ready ? FETCH : MEMWR;
         EXEC:   state_next = RWB;
         RWB:    state_next = FETCH;
         BRANCH: state_next = FETCH;
         JUMP:   state_next = FETCH;
         ADDIEX: state_next = ADDIWB;
         ADDIWB: state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
`ifdef MCTRL_BNE_EN
      taken = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
      taken = bus.zero;
`endif
   end

   always_comb begin
      bus.pcwrite     = 1'b0;
      bus.pcwritecond = 1'b0;
      bus.iord        = 1'b0;
      bus.memread     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.memtoreg    = 1'b0;
      bus.irwrite     = 1'b0;
      bus.regwrite    = 1'b0;
      bus.regdst      = 1'b0;
      bus.alusrca     = 1'b0;
      bus.alusrcb     = 2'b00;
      bus.pcsource    = 2'b00;
      bus.aluop1      = 1'b0;
      bus.aluop0      = 1'b0;
      bus.illegal     = 1'b0;
      case (state_q)
         FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = 2'b01;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            bus.illegal = ~legal;
         end
         MEMADR, ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
         end
         MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
         end
         MEMWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
         end
         EXEC: begin
            bus.alusrca = 1'b1;
            bus.aluop1  = 1'b1;
         end
         RWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
         end
         BRANCH: begin
            bus.alusrca     = 1'b1;
            bus.aluop0      = 1'b1;
            bus.pcwritecond = 1'b1;
            bus.pcsource    = 2'b01;
         end
         JUMP: begin
            bus.pcwrite  = 1'b1;
            bus.pcsource = 2'b10;
         end
         ADDIWB: bus.regwrite = 1'b1;
         default: ;
      endcase
      // Reset is asynchronous to the edge, so the write enables are masked
      // combinationally; everything else already shows FETCH values.
      if (reset) begin
         bus.pcwrite  = 1'b0;
         bus.irwrite  = 1'b0;
         bus.regwrite = 1'b0;
         bus.memwrite = 1'b0;
      end
   end

   assign bus.pcen  = ~reset & (bus.pcwrite | (bus.pcwritecond & taken));
   assign bus.state = state_q;

endmodule

// File: tb/tb_mcycle_control.sv
// tb_mcycle_control: randomized scoreboard bench for mcycle_control.
// The driver walks each instruction through its phase list (derived from
// the opcode), pushes the expected output word for every cycle, and a
// negedge monitor pops and compares against the DUT.
module tb_mcycle_control;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mcycle_control_if bus ();

   mcycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [21:0] exp_q[$];
   int unsigned checks = 0;
   int unsigned passed = 0;
   int unsigned cycle  = 0;

   function automatic bit is_legal(input logic [5:0] op);
      if (op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 ||
          op == 6'd2 || op == 6'd8) return 1'b1;
`ifdef MCTRL_BNE_EN
      if (op == 6'd5) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Sequence of state numbers an instruction passes through (no waits).
   function automatic void phases(input logic [5:0] op, output int seq[$]);
      seq = {0, 1};
      case (op)
         6'd0:  seq = {0, 1, 6, 7};
         6'd35: seq = {0, 1, 2, 3, 4};
         6'd43: seq = {0, 1, 2, 5};
         6'd4:  seq = {0, 1, 8};
         6'd2:  seq = {0, 1, 9};
         6'd8:  seq = {0, 1, 10, 11};
         default: begin
`ifdef MCTRL_BNE_EN
            if (op == 6'd5) seq = {0, 1, 8};
`endif
         end
      endcase
   endfunction

   function automatic logic [21:0] exp_vec(input int st, input logic mr,
                                           input logic z, input logic rs,
                                           input logic [5:0] op);
      logic pw, pwc, io, mrd, mwr, mtr, irw, rw, rd, asa, tk, pcen, ill;
      logic [1:0] asb, psrc, aop;
      logic [3:0] s4;
      {pw, pwc, io, mrd, mwr, mtr, irw, rw, rd, asa} = '0;
      asb = 2'b00; psrc = 2'b00; aop = 2'b00;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; io = 1; end
         4:  begin rw = 1; mtr = 1; end
         5:  begin mwr = 1; io = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      if (rs) begin pw = 0; irw = 0; rw = 0; mwr = 0; end
      tk = z;
`ifdef MCTRL_BNE_EN
      if (op == 6'd5) tk = ~z;
`endif
      pcen = pw | (pwc & tk);
      ill  = (st == 1) && !is_legal(op);
      s4   = 4'(st);
      return {s4, ill, pcen, pw, pwc, io, mrd, mwr, mtr, irw, rw, rd, asa,
              asb, psrc, aop};
   endfunction

   // One cycle of stimulus: drive inputs, push expectation, advance.
   task automatic step(input int st, input logic mr);
      bus.mem_ready = mr;
      bus.zero      = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_vec(st, mr, bus.zero, reset, bus.opcode));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) step(0, 1'($urandom_range(0, 1)));
      reset = 1'b0;
   endtask

   task automatic run_instr(input logic [5:0] op, input int abort_at);
      int seq[$];
      int w;
      bus.opcode = op;
      phases(op, seq);
      foreach (seq[i]) begin
         if (i == abort_at) begin
            do_reset(2);
            return;
         end
         if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
            w = $urandom_range(0, 2);
            for (int k = 0; k < w; k++) step(seq[i], 1'b0);
            step(seq[i], 1'b1);
         end else begin
            step(seq[i], 1'($urandom_range(0, 1)));
         end
      end
   endtask

   always @(negedge clk) begin
      logic [21:0] act, expv;
      cycle++;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         act = {bus.state, bus.illegal, bus.pcen, bus.pcwrite, bus.pcwritecond,
                bus.iord, bus.memread, bus.memwrite, bus.memtoreg, bus.irwrite,
                bus.regwrite, bus.regdst, bus.alusrca, bus.alusrcb,
                bus.pcsource, bus.aluop1, bus.aluop0};
         checks++;
         if (act == expv) passed++;
         else $display("FAIL outputs cycle %0d exp_state %0d: got %b expected %b",
                       cycle, expv[21:18], act, expv);
      end
   end

   initial begin
      logic [5:0] directed[$];
      logic [5:0] op;
      int r;
      directed = {6'd0, 6'd35, 6'd43, 6'd4, 6'd4, 6'd2, 6'd8, 6'd63, 6'd5};
      reset         = 1'b1;
      bus.opcode    = 6'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 1'b1);
      reset = 1'b0;
      foreach (directed[i]) run_instr(directed[i], -1);
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: op = 6'd0;   1: op = 6'd35;  2: op = 6'd43;
            3: op = 6'd4;   4: op = 6'd2;   5: op = 6'd8;
            6: op = 6'd5;
            default: op = 6'($urandom_range(0, 63));
         endcase
         run_instr(op, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
